// File: rtl/qoa_spi_master.sv
// ---------------------------------------------------------------------------
// qoa_spi_master
//   SPI mode-0 master (CPOL=0, CPHA=0, MSB first) for the QOA decoder's SPI
//   slave port. Bytes arrive over a valid/ready handshake; consecutive bytes
//   without tx_last form one burst with chipsel held low. Each received byte
//   is returned on rx_data with a one-cycle rx_valid strobe.
//
// Parameters
//   CLK_DIV  system clocks per SCLK half-period (1..255)
//   CS_GAP   minimum system clocks chipsel stays high after a burst (>=1)
//
// Ports
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset
//   tx_data   in   byte to transmit
//   tx_valid  in   tx_data/tx_last valid
//   tx_last   in   release chipsel after this byte
//   tx_ready  out  byte accepted when tx_valid && tx_ready
//   rx_data   out  last received byte, stable until the next rx_valid
//   rx_valid  out  one-cycle strobe, rx_data newly valid
//   busy      out  chipsel low or post-burst gap running
//   sclk      out  SPI clock, idles low
//   mosi      out  master out
//   miso      in   master in (sampled on rising sclk)
//   chipsel   out  1 = slave deselected, 0 = selected
// ---------------------------------------------------------------------------
module qoa_spi_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       chipsel
);

  localparam int unsigned    GW       = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [7:0]     HALF_MAX = 8'(CLK_DIV - 1);
  localparam logic [GW-1:0]  GAP_MAX  = GW'(CS_GAP - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    NEXT,
    GAP
  } state_e;

  state_e          state_q,    state_d;
  logic [7:0]      half_q,     half_d;
  logic [2:0]      bit_q,      bit_d;
  logic [6:0]      txsh_q,     txsh_d;
  logic            last_q,     last_d;
  logic [7:0]      rxsh_q,     rxsh_d;
  logic [7:0]      rx_data_q,  rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            sclk_q,     sclk_d;
  logic            mosi_q,     mosi_d;
  logic            cs_q,       cs_d;
  logic            ready_q,    ready_d;
  logic [GW-1:0]   gap_q,      gap_d;
  logic            accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      half_q     <= '0;
      bit_q      <= '0;
      txsh_q     <= '0;
      last_q     <= 1'b0;
      rxsh_q     <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_q       <= 1'b1;
      ready_q    <= 1'b0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      bit_q      <= bit_d;
      txsh_q     <= txsh_d;
      last_q     <= last_d;
      rxsh_q     <= rxsh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_q       <= cs_d;
      ready_q    <= ready_d;
      gap_q      <= gap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    bit_d      = bit_q;
    txsh_d     = txsh_q;
    last_d     = last_q;
    rxsh_d     = rxsh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_d       = cs_q;
    gap_d      = gap_q;

    accept = tx_valid && ready_q;

    case (state_q)
      IDLE, NEXT: begin
        if (accept) begin
          state_d = SHIFT;
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = tx_data[7];
          txsh_d  = tx_data[6:0];
          last_d  = tx_last;
          half_d  = '0;
          bit_d   = '0;
          rxsh_d  = '0;
        end
      end

      SHIFT: begin
        // rx_valid_q marks the cycle after the 8th fall: the byte is done and
        // this last SHIFT cycle must not generate another sclk edge.
        if (rx_valid_q) begin
          if (last_q) begin
            state_d = GAP;
            cs_d    = 1'b1;
            gap_d   = '0;
          end else begin
            state_d = NEXT;
          end
        end else if (half_q == HALF_MAX) begin
          half_d = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rxsh_d = {rxsh_q[6:0], miso};
          end else if (bit_q == 3'd7) begin
            rx_data_d  = rxsh_q;
            rx_valid_d = 1'b1;
          end else begin
            mosi_d = txsh_q[6];
            txsh_d = {txsh_q[5:0], 1'b0};
            bit_d  = bit_q + 3'd1;
          end
        end else begin
          half_d = half_q + 8'd1;
        end
      end

      GAP: begin
        if (gap_q == GAP_MAX) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Registered ready: follows the state being entered, so it is low in
    // reset and during SHIFT/GAP, and never overlaps rx_valid.
    ready_d = (state_d == IDLE) || (state_d == NEXT);
  end

  assign tx_ready = ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign chipsel  = cs_q;
  assign busy     = !cs_q || (state_q == GAP);

endmodule

// File: tb/tb_qoa_spi_master.sv
// ---------------------------------------------------------------------------
// tb_qoa_spi_master
//   Bench for qoa_spi_master. Two instances (CLK_DIV=2 and CLK_DIV=1) share
//   the stimulus; sel picks which one is driven and observed. A behavioural
//   SPI slave (fixed, echo or table-driven response) sits on the selected
//   bus; a monitor logs rx bytes, accepted bytes and chipsel-high runs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_qoa_spi_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid, tx_last;
  logic       sel;
  logic       miso = 1'b0;

  logic       tx_ready0, rx_valid0, busy0, sclk0, mosi0, cs0;
  logic [7:0] rx_data0;
  logic       tx_ready1, rx_valid1, busy1, sclk1, mosi1, cs1;
  logic [7:0] rx_data1;
  logic       tx_valid0, tx_valid1;

  always #5 clk = ~clk;

  assign tx_valid0 = tx_valid & ~sel;
  assign tx_valid1 = tx_valid &  sel;

  qoa_spi_master #(.CLK_DIV(2), .CS_GAP(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid0),
    .tx_last(tx_last), .tx_ready(tx_ready0), .rx_data(rx_data0),
    .rx_valid(rx_valid0), .busy(busy0), .sclk(sclk0), .mosi(mosi0),
    .miso(miso), .chipsel(cs0)
  );

  qoa_spi_master #(.CLK_DIV(1), .CS_GAP(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid1),
    .tx_last(tx_last), .tx_ready(tx_ready1), .rx_data(rx_data1),
    .rx_valid(rx_valid1), .busy(busy1), .sclk(sclk1), .mosi(mosi1),
    .miso(miso), .chipsel(cs1)
  );

  logic       cur_tx_ready, cur_rx_valid, cur_busy, cur_sclk, cur_mosi, cur_cs;
  logic [7:0] cur_rx_data;
  assign cur_tx_ready = sel ? tx_ready1 : tx_ready0;
  assign cur_rx_valid = sel ? rx_valid1 : rx_valid0;
  assign cur_busy     = sel ? busy1     : busy0;
  assign cur_sclk     = sel ? sclk1     : sclk0;
  assign cur_mosi     = sel ? mosi1     : mosi0;
  assign cur_cs       = sel ? cs1       : cs0;
  assign cur_rx_data  = sel ? rx_data1  : rx_data0;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural SPI slave (mode 0) ----------------
  int         s_mode = 0;          // 0 fixed, 1 echo, 2 table
  logic [7:0] fixed_resp = 8'h00;
  logic [7:0] resp_tab [64];
  logic [7:0] s_in = 8'h00, s_out = 8'h00;
  int         s_bits = 0, s_idx = 0, rises = 0;
  logic       p_cs = 1'b1, p_sclk = 1'b0;
  logic [7:0] slave_rx [256];
  int         s_rx_n = 0;

  function automatic logic [7:0] pick(input bit first);
    case (s_mode)
      0:       return fixed_resp;
      1:       return first ? fixed_resp : s_in;
      default: return resp_tab[s_idx % 64];
    endcase
  endfunction

  always @(negedge clk) begin
    if (cur_cs) begin
      s_bits = 0;
    end else begin
      if (p_cs) begin
        s_out = pick(1'b1);
        miso  = s_out[7];
      end
      if (cur_sclk && !p_sclk) begin
        s_in = {s_in[6:0], cur_mosi};
        s_bits++;
        rises++;
      end
      if (!cur_sclk && p_sclk) begin
        if (s_bits == 8) begin
          slave_rx[s_rx_n % 256] = s_in;
          s_rx_n++;
          s_idx++;
          s_bits = 0;
          s_out  = pick(1'b0);
          miso   = s_out[7];
        end else begin
          miso = s_out[7 - s_bits];
        end
      end
    end
    p_cs   = cur_cs;
    p_sclk = cur_sclk;
  end

  // ---------------- monitor ----------------
  logic [7:0] rx_mon [256];
  int         rx_csr [256];
  int         rx_n = 0;
  logic [7:0] acc_d [256];
  int         acc_n = 0;
  int         gap_run [256];
  int         gap_rdy0 [256];
  int         gap_n = 0, run = 0, run0 = 0;
  int         cs_rises = 0, cs_falls = 0, proto_err = 0;
  logic       m_pcs = 1'b1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cur_rx_valid && cur_tx_ready) proto_err++;
      if (!cur_cs && !cur_busy)         proto_err++;
    end
    if (cur_rx_valid) begin
      rx_mon[rx_n % 256] = cur_rx_data;
      rx_csr[rx_n % 256] = cs_rises;
      rx_n++;
    end
    if (tx_valid && cur_tx_ready) begin
      acc_d[acc_n % 256] = tx_data;
      acc_n++;
    end
    if (cur_cs && !m_pcs) cs_rises++;
    if (!cur_cs && m_pcs) cs_falls++;
    if (cur_cs) begin
      run++;
      if (!cur_tx_ready) run0++;
    end else if (run > 0) begin
      gap_run[gap_n % 256]  = run;
      gap_rdy0[gap_n % 256] = run0;
      gap_n++;
      run  = 0;
      run0 = 0;
    end
    m_pcs = cur_cs;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a byte with tx_valid held until the handshake edge.
  task automatic send(input logic [7:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (cur_tx_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("send_ready_timeout", 32'(ok), 32'd1);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (cur_tx_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk({tag, "_ready_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_rx(input string tag, input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rx_n >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk({tag, "_rx_timeout"}, 32'(ok), 32'd1);
  endtask

  // One single-byte transfer with edge-exact checks. Edges are numbered from
  // the accept edge E0; sampling happens 1ns after each edge.
  task automatic single(input string tag, input logic [7:0] tx,
                        input logic [7:0] exp_mosi, input logic [7:0] exp_rx);
    int   d, sw, mw, vw, cw, base;
    logic exp_s;
    d  = sel ? 1 : 2;
    sw = 0; mw = 0; vw = 0; cw = 0;
    base = s_rx_n;
    send(tx, 1'b1);
    chk({tag, "_cs_low_E0"}, 32'(cur_cs), 32'd0);
    for (int n = 1; n <= 16 * d + 3; n++) begin
      tick();
      exp_s = (n < 16 * d) && (((n / d) % 2) == 1);
      if (cur_sclk !== exp_s) sw++;
      if ((n < 16 * d) && (n % d == 0) && ((n / d) % 2 == 1))
        if (cur_mosi !== exp_mosi[7 - (n / d) / 2]) mw++;
      if (cur_rx_valid !== (n == 16 * d)) vw++;
      if ((n <= 16 * d) && (cur_cs !== 1'b0)) cw++;
      if (n == 16 * d) chk({tag, "_rx_data"}, 32'(cur_rx_data), 32'(exp_rx));
      if (n == 16 * d + 1) begin
        chk({tag, "_cs_high_gap"}, 32'(cur_cs), 32'd1);
        chk({tag, "_ready_low_gap"}, 32'(cur_tx_ready), 32'd0);
        chk({tag, "_busy_gap"}, 32'(cur_busy), 32'd1);
      end
      if (n == 16 * d + 3) begin
        chk({tag, "_ready_idle"}, 32'(cur_tx_ready), 32'd1);
        chk({tag, "_busy_idle"}, 32'(cur_busy), 32'd0);
        chk({tag, "_rx_data_hold"}, 32'(cur_rx_data), 32'(exp_rx));
      end
    end
    chk({tag, "_sclk_wave_errs"}, 32'(sw), 32'd0);
    chk({tag, "_mosi_bit_errs"}, 32'(mw), 32'd0);
    chk({tag, "_rx_valid_errs"}, 32'(vw), 32'd0);
    chk({tag, "_cs_low_errs"}, 32'(cw), 32'd0);
    chk({tag, "_slave_bytes"}, 32'(s_rx_n - base), 32'd1);
    if (s_rx_n > base)
      chk({tag, "_slave_saw"}, 32'(slave_rx[base % 256]), 32'(exp_mosi));
  endtask

  typedef struct {
    logic       sel;
    logic [7:0] tx;
    logic [7:0] resp;
    logic [7:0] exp_mosi;
    logic [7:0] exp_rx;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt [6];
    int         rx0, srx0, r0, csr0, a0, g0, idx0, nb, cf0, e1, e2, ex;
    logic [7:0] bv, dv, ev;
    logic       lv;
    logic [7:0] sent [32];

    vt[0] = '{1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vt[1] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF};
    vt[2] = '{1'b0, 8'h81, 8'h7E, 8'h81, 8'h7E};
    vt[3] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00};
    vt[4] = '{1'b1, 8'h5A, 8'h96, 8'h5A, 8'h96};
    vt[5] = '{1'b1, 8'hC3, 8'hA5, 8'hC3, 8'hA5};

    sel = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < 64; i++) resp_tab[i] = 8'($urandom);
    repeat (3) tick();
    chk("reset_dut0", {18'd0, cs0, sclk0, mosi0, tx_ready0, rx_valid0, busy0, rx_data0},
        {18'd0, 6'b100000, 8'h00});
    chk("reset_dut1", {18'd0, cs1, sclk1, mosi1, tx_ready1, rx_valid1, busy1, rx_data1},
        {18'd0, 6'b100000, 8'h00});
    rst_n = 1'b1;
    tick();
    tick();
    chk("ready_after_reset", 32'(cur_tx_ready), 32'd1);

    // Table-driven single-byte transfers on both clock dividers.
    for (int i = 0; i < 6; i++) begin
      sel        = vt[i].sel;
      s_mode     = 0;
      fixed_resp = vt[i].resp;
      tick();
      single($sformatf("vec%0d", i), vt[i].tx, vt[i].exp_mosi, vt[i].exp_rx);
    end

    // Reset in the middle of a byte.
    sel = 1'b0; s_mode = 0; fixed_resp = 8'h77;
    tick();
    rx0 = rx_n; srx0 = s_rx_n;
    send(8'hC3, 1'b1);
    repeat (7) tick();
    chk("mid_cs_low_E7", 32'(cur_cs), 32'd0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_state", {28'd0, cur_cs, cur_sclk, cur_rx_valid, cur_tx_ready},
        {28'd0, 4'b1000});
    tick();
    chk("mid_rst_ready_held", 32'(cur_tx_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mid_no_rx_valid", 32'(rx_n - rx0), 32'd0);
    chk("mid_no_slave_byte", 32'(s_rx_n - srx0), 32'd0);
    fixed_resp = 8'h96;
    single("after_rst", 8'h5A, 8'h5A, 8'h96);

    // Two-byte burst against the echo slave.
    s_mode = 1; fixed_resp = 8'hC3;
    tick();
    r0 = rises; rx0 = rx_n; srx0 = s_rx_n; csr0 = cs_rises;
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    wait_rx("burst", rx0 + 2);
    wait_ready("burst");
    chk("burst_rises", 32'(rises - r0), 32'd16);
    chk("burst_rx_count", 32'(rx_n - rx0), 32'd2);
    chk("burst_rx0", 32'(rx_mon[rx0 % 256]), 32'hC3);
    chk("burst_rx1_echo", 32'(rx_mon[(rx0 + 1) % 256]), 32'h11);
    chk("burst_cs_held_1", 32'(rx_csr[rx0 % 256] - csr0), 32'd0);
    chk("burst_cs_held_2", 32'(rx_csr[(rx0 + 1) % 256] - csr0), 32'd0);
    chk("burst_cs_release", 32'(cs_rises - csr0), 32'd1);
    chk("burst_slave0", 32'(slave_rx[srx0 % 256]), 32'h11);
    chk("burst_slave1", 32'(slave_rx[(srx0 + 1) % 256]), 32'h22);

    // Backpressure: tx_valid held high, tx_data changes every cycle.
    s_mode = 0; fixed_resp = 8'h00;
    a0 = acc_n; g0 = gap_n; srx0 = s_rx_n;
    tx_last = 1'b1; tx_valid = 1'b1;
    for (int i = 0; i < 118; i++) begin
      tx_data = 8'(cyc);
      tick();
    end
    tx_valid = 1'b0;
    wait_ready("bp");
    chk("bp_accepts", 32'(acc_n - a0), 32'd4);
    chk("bp_slave_bytes", 32'(s_rx_n - srx0), 32'd4);
    e1 = 0; e2 = 0;
    for (int i = 0; i < 4; i++) begin
      if (slave_rx[(srx0 + i) % 256] !== acc_d[(a0 + i) % 256]) e1++;
      if (i > 0) begin
        bv = acc_d[(a0 + i) % 256] - acc_d[(a0 + i - 1) % 256];
        if (bv !== 8'd36) e2++;
      end
    end
    chk("bp_sent_equals_accepted", 32'(e1), 32'd0);
    chk("bp_accept_spacing_errs", 32'(e2), 32'd0);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("bp_cs_high_run%0d", i), 32'(gap_run[(g0 + i) % 256]), 32'd3);
      chk($sformatf("bp_gap_ready0_run%0d", i), 32'(gap_rdy0[(g0 + i) % 256]), 32'd2);
    end

    // Randomised traffic against the table-response slave.
    s_mode = 2;
    tick();
    idx0 = s_idx; rx0 = rx_n; srx0 = s_rx_n; cf0 = cs_falls; nb = 0;
    for (int j = 0; j < 24; j++) begin
      repeat ($urandom_range(0, 3)) tick();
      dv = 8'($urandom);
      lv = ($urandom_range(0, 2) == 0) || (j == 23);
      sent[j] = dv;
      if (lv) nb++;
      send(dv, lv);
    end
    wait_rx("rand", rx0 + 24);
    wait_ready("rand");
    e1 = 0; e2 = 0;
    for (int j = 0; j < 24; j++) begin
      if (slave_rx[(srx0 + j) % 256] !== sent[j]) e1++;
      ev = resp_tab[(idx0 + j) % 64];
      if (rx_mon[(rx0 + j) % 256] !== ev) e2++;
    end
    chk("rand_rx_count", 32'(rx_n - rx0), 32'd24);
    chk("rand_mosi_errs", 32'(e1), 32'd0);
    chk("rand_miso_errs", 32'(e2), 32'd0);
    chk("rand_bursts", 32'(cs_falls - cf0), 32'(nb));

    // Idle: nothing requested for 100 cycles.
    sel = 1'b1;
    tick();
    rx0 = rx_n; ex = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (cur_sclk !== 1'b0 || cur_cs !== 1'b1 || cur_busy !== 1'b0) ex++;
    end
    chk("idle_errs", 32'(ex), 32'd0);
    chk("idle_no_rx", 32'(rx_n - rx0), 32'd0);

    chk("protocol_errs", 32'(proto_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
